// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high segment patterns
// ({g,f,e,d,c,b,a}, a = bit 0) and a pin-polarity helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD to active-high 7-segment pattern; codes 10-15 show nothing.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: frame-synchronous display latch,
// leading-zero blanking, per-digit decimal points and an anti-ghosting blank interval.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  en,
    input  logic                                                  load,
    input  logic [4*NUM_DIGITS-1:0]                               bcd_in,
    input  logic [NUM_DIGITS-1:0]                                 dp_in,
    input  logic                                                  lz_blank,
    output logic [6:0]                                            seg,
    output logic                                                  dp,
    output logic [NUM_DIGITS-1:0]                                 an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                                  frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF  = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

    logic [PRE_W-1:0]        prescaler_q;
    logic [IDX_W-1:0]        digit_idx_q;
    logic [4*NUM_DIGITS-1:0] hold_bcd_q, disp_bcd_q;
    logic [NUM_DIGITS-1:0]   hold_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_tick_q;

    logic                  slot_end, frame_end, in_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [3:0]            cur_bcd;
    logic                  cur_dp, cur_lz, zero_above;
    logic [6:0]            cur_pat;

    assign slot_end  = (prescaler_q == PRE_LAST);
    assign frame_end = slot_end && (digit_idx_q == IDX_LAST);
    assign in_blank  = 32'(prescaler_q) < BLANK_CYCLES;

    // Walk from the most significant digit down so zero_above covers digits k..N-1.
    always_comb begin
        zero_above = 1'b1;
        sel_onehot = '0;
        cur_bcd    = '0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_bcd_q[4*k +: 4] == 4'd0);
            if (digit_idx_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                cur_bcd       = disp_bcd_q[4*k +: 4];
                cur_dp        = disp_dp_q[k];
                cur_lz        = zero_above && (k != 0);
            end
        end
    end

    seg7_digit_decode u_decode (
        .bcd     (cur_bcd),
        .pattern (cur_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q  <= '0;
            digit_idx_q  <= '0;
            hold_bcd_q   <= '0;
            hold_dp_q    <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            if (load) begin
                hold_bcd_q <= bcd_in;
                hold_dp_q  <= dp_in;
            end
            if (en) begin
                prescaler_q <= slot_end ? '0 : prescaler_q + PRE_W'(1);
                if (slot_end) begin
                    digit_idx_q <= frame_end ? '0 : digit_idx_q + IDX_W'(1);
                end
                // Old hold value wins over a load on the same edge.
                if (frame_end) begin
                    disp_bcd_q <= hold_bcd_q;
                    disp_dp_q  <= hold_dp_q;
                end
                frame_tick_q <= frame_end;
                an_q  <= in_blank ? AN_OFF : (AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot);
                seg_q <= (lz_blank && cur_lz) ? SEG_OFF : seg_polarity(cur_pat, SEG_ACTIVE_LOW);
                dp_q  <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
            end else begin
                frame_tick_q <= 1'b0;
                an_q         <= AN_OFF;
                seg_q        <= SEG_OFF;
                dp_q         <= DP_OFF;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: position-based reference model feeds an
// expectation queue that a separate monitor drains one entry per clock.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;

    logic        clk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       tick;
        bit         chk_seg;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // Active-high patterns indexed by BCD code; invalid codes light nothing.
    logic [6:0] pat_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Model: enabled-cycle count since reset gives slot/digit by plain division.
    int unsigned pos;
    logic [15:0] m_hold, m_disp;
    logic [3:0]  m_hold_dp, m_disp_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pos       = 0;
        m_hold    = '0;
        m_disp    = '0;
        m_hold_dp = '0;
        m_disp_dp = '0;
    endtask

    task automatic step(input logic e, input logic ld, input logic [15:0] b,
                        input logic [3:0] d, input logic lz, input logic clr);
        exp_t x;
        int   ps, dg;
        @(negedge clk);
        if (clr) rst = 1'b0;
        en = e; load = ld; bcd_in = b; dp_in = d; lz_blank = lz;
        ps = int'(pos % RD);
        dg = int'((pos / RD) % ND);
        x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.tick = 1'b0; x.chk_seg = 1'b1;
        if (e) begin
            if (ps >= int'(BC)) x.an = ~(4'b0001 << dg);
            else x.chk_seg = 1'b0;
            if (lz && dg > 0 && (m_disp >> (4 * dg)) == 16'd0) x.seg = 7'h7F;
            else x.seg = ~pat_tab[m_disp[4*dg +: 4]];
            x.dp   = ~m_disp_dp[dg];
            x.tick = (ps == int'(RD) - 1) && (dg == int'(ND) - 1);
            if (x.tick) begin
                m_disp    = m_hold;
                m_disp_dp = m_hold_dp;
            end
            pos++;
        end
        if (ld) begin
            m_hold    = b;
            m_hold_dp = d;
        end
        x.idx = 2'((pos / RD) % ND);
        expq.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, bcd_in, dp_in, lz_blank, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
    endtask

    // Asserted between clock edges so the async path is what gets observed.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && expq.size() > 0) begin
                x = expq.pop_front();
                check("an", 32'(an), 32'(x.an));
                check("digit_idx", 32'(digit_idx), 32'(x.idx));
                check("frame_tick", 32'(frame_tick), 32'(x.tick));
                if (x.chk_seg) begin
                    check("seg", 32'(seg), 32'(x.seg));
                    check("dp", 32'(dp), 32'(x.dp));
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] rb;
        logic        rlz;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; lz_blank = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);

        // Digits 1234, no blanking.
        step(1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0, 1'b1);
        run(40);
        // Leading zeros with and without suppression.
        step(1'b1, 1'b1, 16'h0042, 4'b0000, 1'b1, 1'b0);
        run(24);
        step(1'b1, 1'b0, 16'h0042, 4'b0000, 1'b0, 1'b0);
        run(20);
        // Invalid code, and a decimal point on a blanked leading zero.
        step(1'b1, 1'b1, 16'h00A0, 4'b0100, 1'b1, 1'b0);
        run(40);
        // Second load lands on the frame boundary edge.
        step(1'b1, 1'b1, 16'h1111, 4'b0000, 1'b0, 1'b0);
        run(6);
        while (!((pos % RD == RD - 1) && ((pos / RD) % ND == ND - 1)))
            run(1);
        step(1'b1, 1'b1, 16'h2222, 4'b0000, 1'b0, 1'b0);
        run(40);
        // Freeze mid-slot.
        while (pos % RD != 2) run(1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, bcd_in, dp_in, lz_blank, 1'b0);
        run(20);
        // Async reset during digit 2, then a clean restart.
        while ((pos / RD) % ND != 2) run(1);
        run(1);
        do_reset();
        step(1'b1, 1'b0, bcd_in, dp_in, lz_blank, 1'b1);
        run(40);

        rlz = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 4; k++)
                rb[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 30) == 0) rlz = ~rlz;
            if ($urandom_range(0, 400) == 0) begin
                do_reset();
                step(1'b1, 1'b0, rb, 4'($urandom), rlz, 1'b1);
            end else begin
                step($urandom_range(0, 12) != 0, $urandom_range(0, 5) == 0, rb,
                     4'($urandom), rlz, 1'b0);
            end
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
